// File: rtl/register_file.sv
// 32 x 32 integer register file: two combinational read ports, one write port, write-to-read forwarding.
// Define REGFILE_DEBUG_PORT_EN to add the dbg_addr/dbg_data inspection port.
module register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_enable,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1,
    output logic [DATA_WIDTH-1:0]     rs2,
`ifdef REGFILE_DEBUG_PORT_EN
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_data,
`endif
    input  logic                      write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    // x0 has no storage; index 0 is never written or read.
    logic [DATA_WIDTH-1:0] regs [1:NREGS-1];

    logic wr_hit;
    assign wr_hit = write_enable && (write_addr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[write_addr] <= write_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] stored(
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (addr == REG_ADDR_WIDTH'(i)) val = regs[i];
        end
        return val;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (rst && read_enable && (addr != '0)) begin
            if (wr_hit && (write_addr == addr)) val = write_data;
            else                                val = stored(addr);
        end
        return val;
    endfunction

    always_comb begin
        rs1 = read_port(rs1_addr);
        rs2 = read_port(rs2_addr);
    end

`ifdef REGFILE_DEBUG_PORT_EN
    // Architectural view only: no gating, no forwarding.
    always_comb begin
        dbg_data = stored(dbg_addr);
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        read_enable;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clk          (clk),
        .rst          (rst),
        .read_enable  (read_enable),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1          (rs1),
        .rs2          (rs2),
`ifdef REGFILE_DEBUG_PORT_EN
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
`endif
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        read_enable  = 1'b1;
        rs1_addr     = 5'd1;
        rs2_addr     = 5'd2;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_addr     = '0;
`endif

        // reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_rs1", rs1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rel_rs1", rs1, 32'h0);
        check("rst_rel_rs2", rs2, 32'h0);

        // x0 write discarded
        @(negedge clk);
        rs1_addr     = 5'd0;
        rs2_addr     = 5'd0;
        write_enable = 1'b1;
        write_addr   = 5'd0;
        write_data   = 32'hDEADBEEF;
        #1;
        check("x0_pre_rs1", rs1, 32'h0);
        check("x0_pre_rs2", rs2, 32'h0);
        @(posedge clk);
        #1;
        check("x0_post_rs1", rs1, 32'h0);
        check("x0_post_rs2", rs2, 32'h0);

        // basic write x1
        @(negedge clk);
        write_addr = 5'd1;
        write_data = 32'h12345678;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        write_data   = 32'h0;
        rs1_addr     = 5'd1;
        rs2_addr     = 5'd1;
        #1;
        check("x1_rs1", rs1, 32'h12345678);
        check("x1_rs2", rs2, 32'h12345678);
        read_enable = 1'b0;
        #1;
        check("re0_rs1", rs1, 32'h0);
        check("re0_rs2", rs2, 32'h0);
        read_enable = 1'b1;

        // forwarding on both ports, mid-cycle data change
        @(negedge clk);
        rs1_addr     = 5'd2;
        rs2_addr     = 5'd2;
        write_enable = 1'b1;
        write_addr   = 5'd2;
        write_data   = 32'h11112222;
        #1;
        check("fwd_mid_rs1", rs1, 32'h11112222);
        write_data = 32'hAABBCCDD;
        #1;
        check("fwd_pre_rs1", rs1, 32'hAABBCCDD);
        check("fwd_pre_rs2", rs2, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        write_data   = 32'h0;
        #1;
        check("fwd_post_rs1", rs1, 32'hAABBCCDD);
        check("fwd_post_rs2", rs2, 32'hAABBCCDD);

        // forwarding per port, write dropped before the edge
        @(negedge clk);
        rs1_addr     = 5'd1;
        rs2_addr     = 5'd2;
        write_enable = 1'b1;
        write_addr   = 5'd1;
        write_data   = 32'hCAFEF00D;
        #1;
        check("fwd1_rs1", rs1, 32'hCAFEF00D);
        check("fwd1_rs2", rs2, 32'hAABBCCDD);
        write_enable = 1'b0;
        #1;
        check("nofwd_rs1", rs1, 32'h12345678);

        // back-to-back writes
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd3;
        write_data   = 32'h5555AAAA;
        @(posedge clk);
        #1;
        write_addr = 5'd4;
        write_data = 32'hFFFF0000;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        write_data   = 32'h0;
        rs1_addr     = 5'd3;
        rs2_addr     = 5'd4;
        #1;
        check("b2b_rs1", rs1, 32'h5555AAAA);
        check("b2b_rs2", rs2, 32'hFFFF0000);

`ifdef REGFILE_DEBUG_PORT_EN
        dbg_addr = 5'd4;
        #1;
        check("dbg_x4", dbg_data, 32'hFFFF0000);
`endif

        // async reset between edges
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rs1", rs1, 32'h0);
        check("arst_rs2", rs2, 32'h0);
        rst = 1'b1;
        #1;
        check("arst_rel_rs1", rs1, 32'h0);
        check("arst_rel_rs2", rs2, 32'h0);

        // write while reset held: reset wins
        @(negedge clk);
        rst          = 1'b0;
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'h0BADF00D;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        rst          = 1'b1;
        rs1_addr     = 5'd5;
        rs2_addr     = 5'd1;
        #1;
        check("rstwr_x5", rs1, 32'h0);
        check("rstwr_x1", rs2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
